// File: rtl/enc_pkg.sv
// Shared definitions for the image encrypter and its matching decrypter:
// controller state encoding, keystream LFSR constants and helper functions.
package enc_pkg;

  // Controller states of the byte-serial encrypter
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } enc_state_t;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS      = 16'hB400;
  // Substituted for an all-zero key, which would lock the LFSR at zero
  localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

  // One keystream step: shift right, fold the taps in when a one falls out
  function automatic logic [15:0] lfsr_step(input logic [15:0] state);
    logic [15:0] shifted;
    shifted = state >> 1;
    return state[0] ? (shifted ^ LFSR_TAPS) : shifted;
  endfunction

  // Map a user key to a usable LFSR seed
  function automatic logic [15:0] seed_from_key(input logic [15:0] key);
    return (key == 16'h0000) ? LFSR_ZERO_SEED : key;
  endfunction

  // Byte rotate-left by 0..7; the decrypter applies the inverse rotation
  function automatic logic [7:0] rotl8(input logic [7:0] value, input logic [2:0] amount);
    logic [15:0] doubled;
    doubled = {value, value} << amount;
    return doubled[15:8];
  endfunction

endpackage

// File: rtl/keystream_lfsr.sv
// 16-bit Galois LFSR keystream source. `load` seeds it (zero key mapped to the
// lockup-free seed), `step` advances it once; `ks` is the current low byte.
module keystream_lfsr
  import enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [7:0]  ks
);

  logic [15:0] lfsr_reg;

  // LFSR state: load has priority so a new pass always starts from its seed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= LFSR_ZERO_SEED;
    end else if (load) begin
      lfsr_reg <= seed_from_key(seed);
    end else if (step) begin
      lfsr_reg <= lfsr_step(lfsr_reg);
    end
  end

  assign ks = lfsr_reg[7:0];

endmodule

// File: rtl/image_encrypter.sv
// Byte-serial image encrypter: walks the plaintext ROM, XORs each byte with
// an LFSR keystream byte and writes the result to the same RAM address.
// Optional build macro ENC_ROTATE_EN additionally rotates each ciphertext
// byte left by addr[2:0]; cycle timing is unchanged.
module image_encrypter
  import enc_pkg::*;
#(
  parameter int ADDR_W   = 15,
  parameter int IMG_SIZE = 19200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       key,
  input  logic              encrypter_active,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [7:0]        plain_data,
  output logic [ADDR_W-1:0] write_addr,
  output logic [7:0]        cipher_data,
  output logic              write_en,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_SIZE - 1);

  enc_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [7:0]        cipher_reg;
  logic [7:0]        ks;
  logic [7:0]        xor_byte;
  logic [7:0]        enc_byte;
  logic              lfsr_load;
  logic              lfsr_advance;

  // Seed on an accepted start; advance exactly once per byte in CAPTURE
  assign lfsr_load    = (state_reg == ST_IDLE) && start;
  assign lfsr_advance = (state_reg == ST_CAPTURE);

  keystream_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (key),
    .step  (lfsr_advance),
    .ks    (ks)
  );

  assign xor_byte = plain_data ^ ks;
`ifdef ENC_ROTATE_EN
  assign enc_byte = rotl8(xor_byte, addr_reg[2:0]);
`else
  assign enc_byte = xor_byte;
`endif

  // State and address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  // Ciphertext byte is formed while the ROM data is valid and held for WRITE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipher_reg <= 8'h00;
    end else if (state_reg == ST_CAPTURE) begin
      cipher_reg <= enc_byte;
    end
  end

  // Next-state and address sequencing
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          addr_next  = '0;
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Without the ROM grant the fetch simply waits, for as long as needed
        if (encrypter_active) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (addr_reg == LAST_ADDR) begin
          state_next = ST_DONE;
        end else begin
          addr_next  = addr_reg + ADDR_W'(1);
          state_next = ST_FETCH;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // All outputs decode registered state, so reset clears them immediately
  assign read_addr   = addr_reg;
  assign write_addr  = addr_reg;
  assign cipher_data = cipher_reg;
  assign write_en    = (state_reg == ST_WRITE);
  assign busy        = (state_reg == ST_FETCH) || (state_reg == ST_CAPTURE) ||
                       (state_reg == ST_WRITE);
  assign done        = (state_reg == ST_DONE);

endmodule

// File: tb/tb_image_encrypter.sv
// Self-checking bench for image_encrypter: randomized ROM images and keys,
// a keystream reference model feeding a write scoreboard, plus latency,
// stall, ignored-restart, mid-pass reset and round-trip checks.
module tb_image_encrypter;

  localparam int AW = 8;
  localparam int N  = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   key = 16'h0000;
  logic          encrypter_active = 1'b1;
  logic [AW-1:0] read_addr;
  logic [7:0]    plain_data;
  logic [AW-1:0] write_addr;
  logic [7:0]    cipher_data;
  logic          write_en;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [7:0] rom [0:255];
  logic [7:0] ram [0:255];

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  image_encrypter #(.ADDR_W(AW), .IMG_SIZE(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .key              (key),
    .encrypter_active (encrypter_active),
    .read_addr        (read_addr),
    .plain_data       (plain_data),
    .write_addr       (write_addr),
    .cipher_data      (cipher_data),
    .write_en         (write_en),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears one cycle after the address
  always @(posedge clk) plain_data <= rom[read_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference keystream: x^16+x^14+x^13+x^11+1 Galois register, right shift
  function automatic logic [15:0] ref_next(input logic [15:0] s);
    logic [15:0] r;
    r = s / 2;
    if (s % 2 == 1) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [7:0] rot_left(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] rot_right(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[0], r[7:1]};
    return r;
  endfunction

  // Expected ciphertext for a whole pass under key k
  task automatic push_pass(input logic [15:0] k);
    logic [15:0] s;
    logic [7:0]  c;
    wr_t         w;
    s = (k == 16'h0000) ? 16'hACE1 : k;
    for (int i = 0; i < N; i++) begin
      c = rom[i] ^ s[7:0];
`ifdef ENC_ROTATE_EN
      c = rot_left(c, i % 8);
`endif
      s = ref_next(s);
      w.a = 8'(i);
      w.d = c;
      exp_q.push_back(w);
    end
  endtask

  // Decrypt the captured RAM image and count bytes differing from the ROM
  function automatic int roundtrip_errors(input logic [15:0] k);
    logic [15:0] s;
    logic [7:0]  c;
    int          bad;
    bad = 0;
    s = (k == 16'h0000) ? 16'hACE1 : k;
    for (int i = 0; i < N; i++) begin
      c = ram[i];
`ifdef ENC_ROTATE_EN
      c = rot_right(c, i % 8);
`endif
      if ((c ^ s[7:0]) !== rom[i]) bad++;
      s = ref_next(s);
    end
    return bad;
  endfunction

  // Scoreboard monitor: every write must match the next expected byte
  always @(negedge clk) begin
    if (rst_n) begin
      if (write_en) begin
        ram[write_addr] = cipher_data;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write addr=%0d data=%0h expected no write", write_addr, cipher_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(write_addr), 32'(e.a));
          check("wr_data", 32'(cipher_data), 32'(e.d));
        end
      end
      if (done) check("done_after_all_writes", exp_q.size(), 0);
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_read_addr"}, 32'(read_addr), 0);
    check({tag, "_write_addr"}, 32'(write_addr), 0);
    check({tag, "_cipher_data"}, 32'(cipher_data), 0);
    check({tag, "_write_en"}, 32'(write_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // One pass. stall: hold the grant low 10 cycles in FETCH of byte 2.
  // mid_start: pulse start and change key mid-pass. abort_at >= 0: reset at that write.
  task automatic do_pass(input logic [15:0] k, input bit stall, input bit mid_start,
                         input int abort_at);
    int cyc;
    int stall_left;
    bit stall_done;
    bit finished;
    stall_left = 0;
    stall_done = 0;
    finished   = 0;
    push_pass(k);
    @(negedge clk);
    start = 1'b1;
    key   = k;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    cyc = 1;
    while (cyc < 3000) begin
      if (done) begin
        finished = 1;
        break;
      end
      if (start) start = 1'b0;
      if (stall && !stall_done && stall_left == 0 && write_en && write_addr == 8'd1) begin
        encrypter_active = 1'b0;
        stall_left = 11;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          encrypter_active = 1'b1;
          stall_done = 1;
        end else begin
          check("stall_read_addr", 32'(read_addr), 2);
          check("stall_no_write", 32'(write_en), 0);
        end
      end
      if (mid_start && write_en && write_addr == 8'd50) begin
        start = 1'b1;
        key   = ~k;
      end
      if (abort_at >= 0 && write_en && write_addr == 8'(abort_at)) begin
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("abort_idle_write_en", 32'(write_en), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_after_release_busy", 32'(busy), 0);
        $display("pass key=%04h aborted at byte %0d", k, abort_at);
        return;
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL pass_timeout cycles=%0d expected done", cyc);
      return;
    end
    check("done_latency", cyc, 3 * N + 1 + (stall ? 10 : 0));
    check("done_busy_low", 32'(busy), 0);
    @(negedge clk);
    check("done_single_pulse", 32'(done), 0);
    check("roundtrip", roundtrip_errors(k), 0);
    $display("pass key=%04h stall=%0d mid_start=%0d cycles=%0d", k, stall, mid_start, cyc);
  endtask

  task automatic fill_rom_random();
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = 8'h00;
      ram[i] = 8'h00;
    end
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_reset");

    // Key 1 over an all-zero image: ciphertext starts 01 00 00 00
    do_pass(16'h0001, 0, 0, -1);
    check("key1_b0", 32'(ram[0]), 32'h01);
    check("key1_b1", 32'(ram[1]), 32'h00);
    check("key1_b2", 32'(ram[2]), 32'h00);
    check("key1_b3", 32'(ram[3]), 32'h00);

    // Zero key uses the lockup-free seed
    fill_rom_random();
    do_pass(16'h0000, 0, 0, -1);
    check("key0_first_byte", 32'(ram[0]), 32'(rom[0] ^ 8'hE1));

    // Random key with a 10-cycle grant stall on byte 2
    fill_rom_random();
    do_pass(16'($urandom_range(1, 65535)), 1, 0, -1);

    // Start pulse and key change mid-pass are ignored
    fill_rom_random();
    do_pass(16'($urandom_range(1, 65535)), 0, 1, -1);

    // Reset at byte 100, then a fresh pass with a new key
    fill_rom_random();
    do_pass(16'($urandom_range(1, 65535)), 0, 0, 100);
    do_pass(16'($urandom_range(1, 65535)), 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
